// File: rtl/ram_writer_pkg.sv
// Shared types and constants for the RAM write-side streamer.
// The state encoding, the button bit positions and the default bus widths
// live here so that the top level and any test code agree on them.
package ram_writer_pkg;

   // Top-level operating modes.
   typedef enum logic [1:0] {
      STREAM = 2'd0,
      CLEAR  = 2'd1,
      FULL   = 2'd2
   } state_e;

   // Push-button bit positions inside the btn bus.
   localparam int BTN_W    = 3;
   localparam int BTN_CLR  = 0;
   localparam int BTN_REW  = 1;
   localparam int BTN_HOLD = 2;

   // Default RAM geometry: 16K x 8.
   localparam int DEF_ADDR_W = 14;
   localparam int DEF_DATA_W = 8;

endpackage : ram_writer_pkg

// File: rtl/btn_sync_edge.sv
// Button conditioner: per-bit two-flop synchronizer followed by a
// falling-edge detector. Buttons are active-low, so a falling edge is a
// press. All flops reset to 1 (released) so that releasing reset while a
// button is held does not fabricate a press.
module btn_sync_edge #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_ni,
   input  logic [WIDTH-1:0] btn_i,
   output logic [WIDTH-1:0] level_o,
   output logic [WIDTH-1:0] fall_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;
   logic [WIDTH-1:0] prev_q;

   // Synchronizer chain plus one delayed copy for edge detection.
   always_ff @(posedge clk or negedge rst_ni) begin
      if (!rst_ni) begin
         meta_q <= '1;
         sync_q <= '1;
         prev_q <= '1;
      end else begin
         meta_q <= btn_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign level_o = sync_q;
   // One-cycle pulse while the previous level was released and the current is pressed.
   assign fall_o  = prev_q & ~sync_q;

endmodule : btn_sync_edge

// File: rtl/ram_writer.sv
// Write-side streamer for the single-port RAM scanned by the button reader.
// Bytes arriving on a valid/ready handshake are written to consecutive
// addresses; btn[0] starts a full-memory clear sweep, btn[1] rewinds the
// write pointer, btn[2] (held low) pauses the input stream.
// Optional build macro RAM_WRITER_WRAP_EN: when defined the pointer wraps
// after the last address instead of stopping in FULL, and full stays 0.
module ram_writer
   import ram_writer_pkg::*;
#(
   parameter int                ADDR_W    = DEF_ADDR_W,
   parameter int                DATA_W    = DEF_DATA_W,
   parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BTN_W-1:0]  btn,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              wren,
   output logic [ADDR_W-1:0] address,
   output logic [DATA_W-1:0] data,
   output logic              busy,
   output logic              full,
   output logic              clear_done
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   // Conditioned buttons.
   logic [BTN_W-1:0] btn_lvl;
   logic [BTN_W-1:0] btn_fall;
   logic             clr_req;
   logic             rew_req;
   logic             hold_n;
   logic             unused_btn;

   // Registered state and outputs.
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic              wren_q, wren_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              done_q, done_d;

   logic              xfer;
   logic              ptr_at_last;

   btn_sync_edge #(
      .WIDTH (BTN_W)
   ) u_btn (
      .clk     (clk),
      .rst_ni  (rst),
      .btn_i   (btn),
      .level_o (btn_lvl),
      .fall_o  (btn_fall)
   );

   assign clr_req = btn_fall[BTN_CLR];
   assign rew_req = btn_fall[BTN_REW];
   assign hold_n  = btn_lvl[BTN_HOLD];

   // Clear/rewind only care about presses; hold only about the level.
   assign unused_btn = ^{btn_lvl[BTN_CLR], btn_lvl[BTN_REW], btn_fall[BTN_HOLD]};

   // A pending button request closes the handshake for that cycle so the
   // request is never raced by a byte write.
   assign in_ready    = (state_q == STREAM) && hold_n && !clr_req && !rew_req;
   assign xfer        = in_valid && in_ready;
   assign ptr_at_last = (ptr_q == LAST_ADDR);

   // State, pointer and RAM-port registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= STREAM;
         ptr_q   <= '0;
         wren_q  <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         wren_q  <= wren_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         done_q  <= done_d;
      end
   end

   // Next-state and next-output decode; address/data hold when not writing.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      wren_d  = 1'b0;
      addr_d  = addr_q;
      data_d  = data_q;
      done_d  = 1'b0;

      case (state_q)
         STREAM: begin
            if (clr_req) begin
               // Clear takes priority over a simultaneous rewind.
               state_d = CLEAR;
               ptr_d   = '0;
            end else if (rew_req) begin
               ptr_d = '0;
            end else if (xfer) begin
               wren_d = 1'b1;
               addr_d = ptr_q;
               data_d = in_data;
               ptr_d  = ptr_q + 1'b1;
`ifndef RAM_WRITER_WRAP_EN
               if (ptr_at_last) begin
                  state_d = FULL;
               end
`endif
            end
         end

         CLEAR: begin
            // One write per cycle; buttons and the input stream are ignored.
            wren_d = 1'b1;
            addr_d = ptr_q;
            data_d = CLEAR_VAL;
            ptr_d  = ptr_q + 1'b1;
            if (ptr_at_last) begin
               state_d = STREAM;
               ptr_d   = '0;
               done_d  = 1'b1;
            end
         end

         FULL: begin
            if (clr_req) begin
               state_d = CLEAR;
               ptr_d   = '0;
            end else if (rew_req) begin
               state_d = STREAM;
               ptr_d   = '0;
            end
         end

         default: begin
            state_d = STREAM;
            ptr_d   = '0;
         end
      endcase
   end

   assign wren       = wren_q;
   assign address    = addr_q;
   assign data       = data_q;
   assign clear_done = done_q;
   assign busy       = (state_q == CLEAR);
`ifdef RAM_WRITER_WRAP_EN
   assign full       = 1'b0;
`else
   assign full       = (state_q == FULL);
`endif

endmodule : ram_writer

// File: tb/tb_ram_writer.sv
// Self-checking bench for ram_writer (small 256-deep RAM so sweeps are short).
module tb_ram_writer;

   localparam int        AW    = 8;
   localparam int        DW    = 8;
   localparam int        DEPTH = 1 << AW;
   localparam logic [7:0] CV   = 8'h00;
`ifdef RAM_WRITER_WRAP_EN
   localparam bit WRAP          = 1'b1;
   localparam int EXP_FULL_WR   = DEPTH + 1;
   localparam int EXP_FULL      = 0;
   localparam int EXP_LAST_ADDR = 0;
   localparam int EXP_FULL_RDY  = 1;
`else
   localparam bit WRAP          = 1'b0;
   localparam int EXP_FULL_WR   = DEPTH;
   localparam int EXP_FULL      = 1;
   localparam int EXP_LAST_ADDR = DEPTH - 1;
   localparam int EXP_FULL_RDY  = 0;
`endif

   logic          clk;
   logic          rst;
   logic [2:0]    btn;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          wren;
   logic [AW-1:0] address;
   logic [DW-1:0] data;
   logic          busy;
   logic          full;
   logic          clear_done;

   ram_writer #(
      .ADDR_W    (AW),
      .DATA_W    (DW),
      .CLEAR_VAL (CV)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn        (btn),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .wren       (wren),
      .address    (address),
      .data       (data),
      .busy       (busy),
      .full       (full),
      .clear_done (clear_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk;
   int n_fail;
   int n_wr_seen;
   int n_done_seen;

   // Reference model: mode 0 = streaming, 1 = clearing, 2 = full.
   int         m_mode;
   int         m_ptr;
   int         clr_left;
   logic [2:0] hist [4];   // hist[i] = button value driven i cycles ago
   logic       e_wren;
   int         e_addr;
   logic [7:0] e_data;
   logic       e_done;

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       ew;
      int         ea;
      logic [7:0] ed;
   } vec_t;
   vec_t tbl [7];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic reset_model();
      m_mode   = 0;
      m_ptr    = 0;
      clr_left = 0;
      for (int i = 0; i < 4; i++) hist[i] = 3'b111;
      e_wren = 1'b0;
      e_addr = 0;
      e_data = 8'h00;
      e_done = 1'b0;
   endtask

   // One clock cycle: drive at the falling edge, check readiness, predict,
   // let the rising edge happen, check registered outputs at the next fall.
   task automatic tick(input logic v, input logic [7:0] d, input logic [2:0] b);
      logic clr, rew, hold, rdy, acc;
      in_valid = v;
      in_data  = d;
      btn      = b;
      hist[3] = hist[2];
      hist[2] = hist[1];
      hist[1] = hist[0];
      hist[0] = b;
      // Two synchronizer stages: a press driven in cycle c is seen in cycle c+2.
      clr  = hist[3][0] & ~hist[2][0];
      rew  = hist[3][1] & ~hist[2][1];
      hold = hist[2][2];
      rdy  = (m_mode == 0) && hold && !clr && !rew;
      #1;
      chk("in_ready", 32'(in_ready), 32'(rdy));
      acc    = v && rdy;
      e_wren = 1'b0;
      e_done = 1'b0;
      case (m_mode)
         0: begin
            if (clr) begin
               m_mode = 1; clr_left = DEPTH;
            end else if (rew) begin
               m_ptr = 0;
            end else if (acc) begin
               e_wren = 1'b1; e_addr = m_ptr; e_data = d;
               m_ptr  = (m_ptr + 1) % DEPTH;
               if (m_ptr == 0 && !WRAP) m_mode = 2;
            end
         end
         1: begin
            e_wren   = 1'b1;
            e_addr   = DEPTH - clr_left;
            e_data   = CV;
            clr_left = clr_left - 1;
            if (clr_left == 0) begin
               m_mode = 0; m_ptr = 0; e_done = 1'b1;
            end
         end
         default: begin
            if (clr) begin
               m_mode = 1; clr_left = DEPTH;
            end else if (rew) begin
               m_mode = 0; m_ptr = 0;
            end
         end
      endcase
      @(posedge clk);
      @(negedge clk);
      chk("wren",       32'(wren),       32'(e_wren));
      chk("address",    32'(address),    e_addr);
      chk("data",       32'(data),       32'(e_data));
      chk("busy",       32'(busy),       32'(m_mode == 1));
      chk("full",       32'(full),       32'(m_mode == 2));
      chk("clear_done", 32'(clear_done), 32'(e_done));
      if (wren)       n_wr_seen++;
      if (clear_done) n_done_seen++;
   endtask

   initial begin
      logic [2:0] rb;
      n_chk = 0; n_fail = 0; n_wr_seen = 0; n_done_seen = 0;

      tbl[0] = '{1'b1, 8'hA5, 1'b1, 0, 8'hA5};
      tbl[1] = '{1'b1, 8'h3C, 1'b1, 1, 8'h3C};
      tbl[2] = '{1'b1, 8'hFF, 1'b1, 2, 8'hFF};
      tbl[3] = '{1'b0, 8'h00, 1'b0, 2, 8'hFF};
      tbl[4] = '{1'b0, 8'h5A, 1'b0, 2, 8'hFF};
      tbl[5] = '{1'b1, 8'h22, 1'b1, 3, 8'h22};
      tbl[6] = '{1'b1, 8'h33, 1'b1, 4, 8'h33};

      rst = 1'b0; btn = 3'b111; in_valid = 1'b0; in_data = '0;
      reset_model();
      repeat (2) @(negedge clk);
      #1;
      chk("rst_wren",  32'(wren),       0);
      chk("rst_addr",  32'(address),    0);
      chk("rst_data",  32'(data),       0);
      chk("rst_busy",  32'(busy),       0);
      chk("rst_full",  32'(full),       0);
      chk("rst_done",  32'(clear_done), 0);
      chk("rst_ready", 32'(in_ready),   1);
      rst = 1'b1;
      @(negedge clk);

      // Basic streaming from the vector table.
      for (int i = 0; i < 7; i++) begin
         tick(tbl[i].v, tbl[i].d, 3'b111);
         chk("tbl_wren", 32'(wren),    32'(tbl[i].ew));
         chk("tbl_addr", 32'(address), tbl[i].ea);
         chk("tbl_data", 32'(data),    32'(tbl[i].ed));
      end

      // Rewind after five writes, then 0x11 lands at address 0.
      repeat (3) tick(1'b0, 8'h00, 3'b101);
      repeat (3) tick(1'b0, 8'h00, 3'b111);
      tick(1'b1, 8'h11, 3'b111);
      chk("rew_addr", 32'(address), 0);
      chk("rew_data", 32'(data),    32'h11);

      // Hold pauses the stream with valid held high.
      repeat (4) tick(1'b1, 8'($urandom), 3'b011);
      repeat (4) tick(1'b1, 8'($urandom), 3'b111);

      // Full clear sweep.
      n_wr_seen = 0; n_done_seen = 0;
      tick(1'b0, 8'h00, 3'b110);
      tick(1'b0, 8'h00, 3'b110);
      tick(1'b0, 8'h00, 3'b111);
      for (int i = 0; i < DEPTH + 20 && n_done_seen == 0; i++)
         tick(1'($urandom), 8'($urandom), 3'b111);
      chk("clr_writes",   n_wr_seen,   DEPTH);
      chk("clr_done_cnt", n_done_seen, 1);
      tick(1'b1, 8'h77, 3'b111);
      chk("post_clr_addr", 32'(address), 0);
      chk("post_clr_data", 32'(data),    32'h77);

      // Fill to the end of memory from a rewound pointer.
      repeat (3) tick(1'b0, 8'h00, 3'b101);
      repeat (3) tick(1'b0, 8'h00, 3'b111);
      n_wr_seen = 0;
      for (int i = 0; i < DEPTH + 1; i++) tick(1'b1, 8'($urandom), 3'b111);
      chk("full_writes",    n_wr_seen,         EXP_FULL_WR);
      chk("full_flag",      32'(full),         EXP_FULL);
      chk("full_last_addr", 32'(address),      EXP_LAST_ADDR);
      #1;
      chk("full_ready",     32'(in_ready),     EXP_FULL_RDY);
      repeat (3) tick(1'b1, 8'h00, 3'b101);
      repeat (3) tick(1'b0, 8'h00, 3'b111);
      chk("full_cleared",   32'(full),         0);

      // Randomized mix of traffic and button activity.
      for (int i = 0; i < 600; i++) begin
         rb = 3'b111;
         if ($urandom_range(0, 199) == 0) rb[0] = 1'b0;
         if ($urandom_range(0, 39)  == 0) rb[1] = 1'b0;
         if ($urandom_range(0, 15)  == 0) rb[2] = 1'b0;
         tick(1'($urandom), 8'($urandom), rb);
      end
      repeat (DEPTH + 8) tick(1'b0, 8'h00, 3'b111);

      // Reset in the middle of a clear sweep.
      tick(1'b0, 8'h00, 3'b110);
      tick(1'b0, 8'h00, 3'b111);
      for (int i = 0; i < DEPTH + 10; i++) begin
         tick(1'b0, 8'h00, 3'b111);
         if (busy && wren && address == AW'(100)) break;
      end
      chk("mid_busy", 32'(busy),    1);
      chk("mid_addr", 32'(address), 100);
      #2 rst = 1'b0;
      #1;
      chk("mid_rst_wren",  32'(wren),       0);
      chk("mid_rst_addr",  32'(address),    0);
      chk("mid_rst_data",  32'(data),       0);
      chk("mid_rst_busy",  32'(busy),       0);
      chk("mid_rst_full",  32'(full),       0);
      chk("mid_rst_done",  32'(clear_done), 0);
      chk("mid_rst_ready", 32'(in_ready),   1);
      reset_model();
      #1 rst = 1'b1;
      @(negedge clk);
      n_done_seen = 0;
      repeat (40) tick(1'($urandom), 8'($urandom), 3'b111);
      chk("no_done_after_rst", n_done_seen, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule : tb_ram_writer
